// File: rtl/soc_evt_id_sender.sv
// soc_evt_id_sender
// Producer end of the SoC event-ID channel. Single-cycle event pulses from
// the peripherals go into per-source saturating pending counters. A
// round-robin arbiter picks among those counters and one software-injected
// request, and pushes one ID per accepted transfer into the cluster-side
// event-ID FIFO.
//
// Handshakes:
//   FIFO side     : fifo_data_valid_o is driven straight from a register and
//                   never looks at fifo_fulln_i. A transfer happens on every
//                   rising edge where fifo_data_valid_o and fifo_fulln_i are
//                   both high. Data and valid stay stable until then.
//   Software side : sw_evt_valid_i is held, with sw_evt_id_i stable, until
//                   sw_evt_ready_o is seen high. Ready is combinational. It
//                   depends on fifo_fulln_i through the output-stage load
//                   enable. The request is consumed on the edge that closes
//                   the ready cycle.
module soc_evt_id_sender #(
   parameter int unsigned NB_EVENTS = 32,
   parameter int unsigned ID_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NB_EVENTS-1:0] evt_i,
   input  logic                 sw_evt_valid_i,
   input  logic [ID_WIDTH-1:0]  sw_evt_id_i,
   output logic                 sw_evt_ready_o,
   output logic                 fifo_data_valid_o,
   input  logic                 fifo_fulln_i,
   output logic [ID_WIDTH-1:0]  fifo_data_o,
   output logic [NB_EVENTS-1:0] overflow_o,
   input  logic                 ovf_clr_i,
   output logic                 busy_o
);

   // Slots 0..NB_EVENTS-1 are hardware sources. Slot NB_EVENTS is software.
   localparam int unsigned NB_SLOTS = NB_EVENTS + 1;
   localparam int unsigned SLOT_W   = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;

   typedef logic [CNT_WIDTH-1:0] cnt_t;
   typedef logic [SLOT_W-1:0]    slot_t;

   localparam cnt_t  CNT_MAX  = '1;
   localparam slot_t SW_SLOT  = slot_t'(NB_EVENTS);
   localparam slot_t SLOT_ONE = slot_t'(1);

   // Output stage.
   logic                valid_q;
   logic [ID_WIDTH-1:0] data_q;
   logic                transfer;
   logic                load_en;

   // Arbitration.
   slot_t               rr_q;
   slot_t               rr_next;
   slot_t               winner;
   logic                found;
   logic                grant;
   logic                sw_grant;
   logic [NB_SLOTS-1:0] eligible;
   int                  idx;

   // Per-source bookkeeping.
   cnt_t                 cnt_q [NB_EVENTS];
   logic [NB_EVENTS-1:0] pending;
   logic [NB_EVENTS-1:0] hw_grant;
   logic [NB_EVENTS-1:0] ovf_set;
   logic [NB_EVENTS-1:0] ovf_q;

   // The output register can take a new ID when it is empty or is emptying
   // this cycle. That gives back-to-back grants under continuous fulln.
   assign transfer = valid_q & fifo_fulln_i;
   assign load_en  = ~valid_q | transfer;

   assign eligible = {sw_evt_valid_i, pending};

   // Find the first eligible slot, searching from rr_q and wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < int'(NB_SLOTS); k++) begin
         idx = int'(rr_q) + k;
         if (idx >= int'(NB_SLOTS)) begin
            idx = idx - int'(NB_SLOTS);
         end
         if (!found && eligible[idx[SLOT_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[SLOT_W-1:0];
         end
      end
   end

   assign grant    = found & load_en;
   assign sw_grant = grant & (winner == SW_SLOT);

   // While reset is held the registers are cleared. Ready is gated so that
   // no software request is acknowledged and lost during reset.
   assign sw_evt_ready_o = sw_grant & rst_ni;

   // The pointer advances past the winner. After the software slot it wraps to 0.
   always_comb begin
      rr_next = rr_q;
      if (grant) begin
         if (winner == SW_SLOT) begin
            rr_next = '0;
         end else begin
            rr_next = winner + SLOT_ONE;
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_next;
      end
   end

   // Output register. It loads on a grant and empties on a transfer that has no refill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (grant) begin
         valid_q <= 1'b1;
         if (sw_grant) begin
            data_q <= sw_evt_id_i;
         end else begin
            data_q <= ID_WIDTH'(winner);
         end
      end else if (transfer) begin
         valid_q <= 1'b0;
      end
   end

   // Per-source pending counters and overflow detection.
   for (genvar i = 0; i < int'(NB_EVENTS); i++) begin : g_src
      logic inc;
      logic dec;

      assign inc         = evt_i[i];
      assign dec         = hw_grant[i];
      assign hw_grant[i] = grant & (winner == slot_t'(i));
      assign pending[i]  = (cnt_q[i] != '0);
      // An event is lost only when it arrives at a full counter and no grant
      // frees a place in the same cycle.
      assign ovf_set[i]  = inc & ~dec & (cnt_q[i] == CNT_MAX);

      // Counter: count up on an event, down on a grant, hold when both or neither occur.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q[i] <= '0;
         end else if (inc && !dec && (cnt_q[i] != CNT_MAX)) begin
            cnt_q[i] <= cnt_q[i] + cnt_t'(1);
         end else if (!inc && dec) begin
            cnt_q[i] <= cnt_q[i] - cnt_t'(1);
         end
      end
   end

   // Sticky overflow flags. A new loss in the clearing cycle stays set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= '0;
      end else if (ovf_clr_i) begin
         ovf_q <= ovf_set;
      end else begin
         ovf_q <= ovf_q | ovf_set;
      end
   end

   assign fifo_data_valid_o = valid_q;
   assign fifo_data_o       = data_q;
   assign overflow_o        = ovf_q;
   assign busy_o            = valid_q | (|pending);

endmodule
